// File: rtl/aig_eval_seq.sv
// aig_eval_seq -- programmable sequential and-inverter-graph evaluator.
//
// A netlist of up to MAX_NODES 2-input AND nodes, each with two fanin literals,
// is stored on chip, together with an output map from each output to a literal.
// Each accepted input vector is evaluated one node per clock in slot order. The
// output vector is then built in one cycle and offered on a valid/ready
// handshake.
//
// Literal encoding: lit = 2*var + c, where c complements the value. var 0 is
// constant 0, vars 1..NUM_IN are the inputs, and var NUM_IN+1+k is node slot k.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   prog_we/addr/lit0/1 write one AND node (honoured only while idle)
//   omap_we/idx/lit     write one output-map entry (honoured only while idle)
//   cfg_nodes           active node count, sampled when a vector is accepted
//   in_valid/ready/vec  input vector handshake
//   out_valid/ready/vec result handshake
//   busy                the block is not idle
//   prog_err            one-cycle pulse after a dropped or illegal write
//
// Optional build macro AIG_EVAL_STATS_EN adds stats_clr (in) and a saturating
// 32-bit eval_count (out) of completed output handshakes.
module aig_eval_seq #(
    parameter int NUM_IN    = 16,
    parameter int NUM_OUT   = 22,
    parameter int MAX_NODES = 256,
    localparam int LIT_W    = $clog2(2 * (1 + NUM_IN + MAX_NODES)),
    localparam int AW       = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
    localparam int OW       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int CW       = $clog2(MAX_NODES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [LIT_W-1:0]   prog_lit0,
    input  logic [LIT_W-1:0]   prog_lit1,
    input  logic               omap_we,
    input  logic [OW-1:0]      omap_idx,
    input  logic [LIT_W-1:0]   omap_lit,
    input  logic [CW-1:0]      cfg_nodes,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_vec,
    output logic               busy,
    output logic               prog_err
`ifdef AIG_EVAL_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [31:0]        eval_count
`endif
);
    localparam int NV = 1 + NUM_IN + MAX_NODES;   // variables, including const 0
    localparam int VW = LIT_W - 1;                // variable index width

    typedef enum logic [1:0] {IDLE, EVAL, MAP, HOLD} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   k_q, k_d;
    logic [CW-1:0]                   nodes_q, nodes_d;
    logic [NV-1:1]                   val_q, val_d;
    logic [NUM_OUT-1:0]              out_vec_q, out_vec_d;
    logic                            out_valid_q, out_valid_d;
    logic                            prog_err_q, prog_err_d;
    logic [MAX_NODES-1:0][LIT_W-1:0] lit0_q, lit0_d, lit1_q, lit1_d;
    logic [NUM_OUT-1:0][LIT_W-1:0]   omap_q, omap_d;

    // Variable 0 is the constant-false variable and has no storage.
    logic [NV-1:0] vals;
    assign vals = {val_q, 1'b0};

    function automatic logic lit_val(input logic [LIT_W-1:0] l, input logic [NV-1:0] v);
        return v[l[LIT_W-1:1]] ^ l[0];
    endfunction

    function automatic logic lit_ok(input logic [LIT_W-1:0] l);
        return 32'(l[LIT_W-1:1]) <= NUM_IN + MAX_NODES;
    endfunction

    logic [VW-1:0] wr_idx;
    assign wr_idx = VW'(NUM_IN + 1) + VW'(k_q);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        nodes_d     = nodes_q;
        val_d       = val_q;
        out_vec_d   = out_vec_q;
        out_valid_d = out_valid_q;
        lit0_d      = lit0_q;
        lit1_d      = lit1_q;
        omap_d      = omap_q;
        prog_err_d  = 1'b0;

        // Node and map writes are independent; each is dropped on its own.
        if (prog_we) begin
            if (state_q == IDLE && lit_ok(prog_lit0) && lit_ok(prog_lit1)
                && 32'(prog_addr) < MAX_NODES) begin
                lit0_d[prog_addr] = prog_lit0;
                lit1_d[prog_addr] = prog_lit1;
            end else begin
                prog_err_d = 1'b1;
            end
        end
        if (omap_we) begin
            if (state_q == IDLE && lit_ok(omap_lit) && 32'(omap_idx) < NUM_OUT) begin
                omap_d[omap_idx] = omap_lit;
            end else begin
                prog_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d[NUM_IN:1] = in_vec;
                    nodes_d = (cfg_nodes > CW'(MAX_NODES)) ? CW'(MAX_NODES) : cfg_nodes;
                    k_d     = '0;
                    state_d = (cfg_nodes == '0) ? MAP : EVAL;
                end
            end
            EVAL: begin
                // Forward references simply read whatever the store holds.
                val_d[wr_idx] = lit_val(lit0_q[k_q[AW-1:0]], vals)
                              & lit_val(lit1_q[k_q[AW-1:0]], vals);
                k_d = k_q + CW'(1);
                if (k_q == nodes_q - CW'(1)) state_d = MAP;
            end
            MAP: begin
                for (int j = 0; j < NUM_OUT; j++) out_vec_d[j] = lit_val(omap_q[j], vals);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            nodes_q     <= '0;
            val_q       <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            prog_err_q  <= 1'b0;
            lit0_q      <= '0;
            lit1_q      <= '0;
            omap_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nodes_q     <= nodes_d;
            val_q       <= val_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            prog_err_q  <= prog_err_d;
            lit0_q      <= lit0_d;
            lit1_q      <= lit1_d;
            omap_q      <= omap_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign prog_err  = prog_err_q;

`ifdef AIG_EVAL_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    // Clear has priority over a same-cycle handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) cnt_d = '0;
        else if (out_valid_q && out_ready && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign eval_count = cnt_q;
`endif
endmodule

// File: tb/tb_aig_eval_seq.sv
module tb_aig_eval_seq;
    localparam int NI = 2, NO = 22, MN = 8;
    localparam int LW = 5, AW = 3, OW = 5, CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [LW-1:0] prog_lit0 = '0, prog_lit1 = '0;
    logic          omap_we = 1'b0;
    logic [OW-1:0] omap_idx = '0;
    logic [LW-1:0] omap_lit = '0;
    logic [CW-1:0] cfg_nodes = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI-1:0] in_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NO-1:0] out_vec;
    logic          busy;
    logic          prog_err;
`ifdef AIG_EVAL_STATS_EN
    logic          stats_clr = 1'b0;
    logic [31:0]   eval_count;
`endif

    localparam logic [NO-1:0] ONES = {NO{1'b1}};

    int n_vec = 0;
    int n_err = 0;

    aig_eval_seq #(.NUM_IN(NI), .NUM_OUT(NO), .MAX_NODES(MN)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_lit0(prog_lit0), .prog_lit1(prog_lit1),
        .omap_we(omap_we), .omap_idx(omap_idx), .omap_lit(omap_lit),
        .cfg_nodes(cfg_nodes),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .busy(busy), .prog_err(prog_err)
`ifdef AIG_EVAL_STATS_EN
        , .stats_clr(stats_clr), .eval_count(eval_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prog_node(input int k, input int l0, input int l1);
        prog_we = 1'b1; prog_addr = AW'(k); prog_lit0 = LW'(l0); prog_lit1 = LW'(l1);
        tick;
        prog_we = 1'b0;
    endtask

    task automatic prog_out(input int j, input int l);
        omap_we = 1'b1; omap_idx = OW'(j); omap_lit = LW'(l);
        tick;
        omap_we = 1'b0;
    endtask

    task automatic map_all(input int l);
        for (int j = 0; j < NO; j++) prog_out(j, l);
    endtask

    // XOR: n0 = x1&~x2, n1 = ~x1&x2, n2 = ~n0&~n1 (xnor); lit11 = xor.
    task automatic load_xor;
        prog_node(0, 2, 5);
        prog_node(1, 3, 4);
        prog_node(2, 7, 9);
        map_all(11);
    endtask

    task automatic start(input logic [NI-1:0] v, input int n);
        in_valid = 1'b1; in_vec = v; cfg_nodes = CW'(n);
        tick;
        in_valid = 1'b0;
    endtask

    // Cycles after the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_vec !== '0) begin n_err++; $display("FAIL rst_out_vec: got %h want 0", out_vec); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (prog_err !== 1'b0) begin n_err++; $display("FAIL rst_prog_err: got %b want 0", prog_err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_xor;
        logic [NI-1:0] vecs [4];
        int lat;
        logic [NO-1:0] want;
        vecs = '{2'b11, 2'b00, 2'b10, 2'b01};
        // Node and map write in the same cycle are both performed.
        prog_we = 1'b1; prog_addr = 3'd0; prog_lit0 = 5'd2; prog_lit1 = 5'd5;
        omap_we = 1'b1; omap_idx = 5'd0; omap_lit = 5'd11;
        tick;
        prog_we = 1'b0; omap_we = 1'b0;
        n_vec++; if (prog_err !== 1'b0) begin n_err++; $display("FAIL xor_legal_write_err: got %b want 0", prog_err); end
        prog_node(1, 3, 4);
        prog_node(2, 7, 9);
        for (int j = 1; j < NO; j++) prog_out(j, 11);
        for (int i = 0; i < 4; i++) begin
            want = (vecs[i][0] ^ vecs[i][1]) ? ONES : '0;
            start(vecs[i], 3);
            n_vec++; if ({in_ready, busy} !== 2'b01) begin n_err++; $display("FAIL xor_eval_flags: got %b want 01", {in_ready, busy}); end
            wait_out(lat);
            n_vec++; if (lat !== 4) begin n_err++; $display("FAIL xor_latency: got %0d want 4", lat); end
            n_vec++; if (out_vec !== want) begin n_err++; $display("FAIL xor_out vec=%b: got %h want %h", vecs[i], out_vec, want); end
            handshake;
        end
    endtask

    task automatic test_const;
        int lat;
        prog_out(0, 1);
        // Map write coinciding with the accept must be used by this evaluation.
        omap_we = 1'b1; omap_idx = 5'd1; omap_lit = 5'd0;
        in_valid = 1'b1; in_vec = 2'b11; cfg_nodes = '0;
        tick;
        omap_we = 1'b0; in_valid = 1'b0;
        wait_out(lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL const_latency: got %0d want 1", lat); end
        n_vec++; if (out_vec[1:0] !== 2'b01) begin n_err++; $display("FAIL const_out: got %b want 01", out_vec[1:0]); end
        handshake;
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL const_release: got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_backpressure;
        int lat;
        prog_out(0, 11);
        prog_out(1, 11);
        start(2'b10, 3);
        wait_out(lat);
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL bp_out: got %h want %h", out_vec, ONES); end
        in_valid = 1'b1;   // offered during HOLD; must not be taken
        for (int c = 0; c < 10; c++) begin
            tick;
            n_vec++;
            if ({out_valid, in_ready} !== 2'b10 || out_vec !== ONES) begin
                n_err++; $display("FAIL bp_hold cyc=%0d: got v=%b r=%b vec=%h want v=1 r=0 vec=%h",
                                  c, out_valid, in_ready, out_vec, ONES);
            end
        end
        in_valid = 1'b0;
        handshake;
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_back_to_back;
        int cnt;
        out_ready = 1'b1;
        start(2'b01, 3);
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            tick;
            cnt++;
        end
        out_ready = 1'b0;
        // Accept to ready again is cfg_nodes+2 edges: a period of cfg_nodes+3.
        n_vec++; if (cnt !== 5) begin n_err++; $display("FAIL b2b_period: got %0d want 5", cnt); end
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL b2b_out: got %h want %h", out_vec, ONES); end
    endtask

    task automatic test_prog_busy;
        int lat;
        start(2'b01, 3);
        prog_we = 1'b1; prog_addr = 3'd2; prog_lit0 = 5'd0; prog_lit1 = 5'd0;
        tick;
        prog_we = 1'b0;
        n_vec++; if (prog_err !== 1'b1) begin n_err++; $display("FAIL busy_err_pulse: got %b want 1", prog_err); end
        tick;
        n_vec++; if (prog_err !== 1'b0) begin n_err++; $display("FAIL busy_err_end: got %b want 0", prog_err); end
        wait_out(lat);
        n_vec++; if (lat + 2 !== 4) begin n_err++; $display("FAIL busy_latency: got %0d want 4", lat + 2); end
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL busy_out: got %h want %h", out_vec, ONES); end
        handshake;
        // Node 2 still xnor: vec 11 gives all zeros (AND(0,0) would give ones).
        start(2'b11, 3);
        wait_out(lat);
        n_vec++; if (out_vec !== '0) begin n_err++; $display("FAIL busy_rerun: got %h want 0", out_vec); end
        handshake;
        prog_node(0, 2 * (NI + MN + 1), 2);
        n_vec++; if (prog_err !== 1'b1) begin n_err++; $display("FAIL illegal_node_err: got %b want 1", prog_err); end
        prog_out(0, 2 * (NI + MN + 1) + 1);
        n_vec++; if (prog_err !== 1'b1) begin n_err++; $display("FAIL illegal_omap_err: got %b want 1", prog_err); end
        start(2'b01, 3);
        wait_out(lat);
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL illegal_unchanged: got %h want %h", out_vec, ONES); end
        handshake;
    endtask

    task automatic test_reset_eval;
        int lat;
        // n3 = xor & 1, n4 = n3 & n3; lit14 = xor.
        prog_node(3, 11, 1);
        prog_node(4, 12, 12);
        map_all(14);
        start(2'b10, 5);
        wait_out(lat);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL five_latency: got %0d want 6", lat); end
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL five_out: got %h want %h", out_vec, ONES); end
        handshake;
        start(2'b01, 5);
        tick; tick; tick;   // k = 3
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_vec !== '0) begin
            n_err++; $display("FAIL rst_in_eval: got v=%b r=%b busy=%b vec=%h want v=0 r=1 busy=0 vec=0",
                              out_valid, in_ready, busy, out_vec);
        end
        tick;
        rst = 1'b0;
        tick;
        load_xor;
        prog_node(3, 11, 1);
        prog_node(4, 12, 12);
        map_all(14);
        // cfg_nodes 15 clamps to 8; cleared slots 5..7 evaluate to 0 harmlessly.
        start(2'b01, 15);
        wait_out(lat);
        n_vec++; if (lat !== 9) begin n_err++; $display("FAIL clamp_latency: got %0d want 9", lat); end
        n_vec++; if (out_vec !== ONES) begin n_err++; $display("FAIL rerun_out: got %h want %h", out_vec, ONES); end
        handshake;
        start(2'b11, 15);
        wait_out(lat);
        n_vec++; if (out_vec !== '0) begin n_err++; $display("FAIL rerun_out11: got %h want 0", out_vec); end
        handshake;
    endtask

`ifdef AIG_EVAL_STATS_EN
    task automatic test_stats;
        int lat;
        stats_clr = 1'b1;
        tick;
        stats_clr = 1'b0;
        n_vec++; if (eval_count !== 32'd0) begin n_err++; $display("FAIL stats_clr: got %0d want 0", eval_count); end
        for (int i = 0; i < 5; i++) begin
            start(2'b01, 0);
            wait_out(lat);
            handshake;
        end
        n_vec++; if (eval_count !== 32'd5) begin n_err++; $display("FAIL stats_five: got %0d want 5", eval_count); end
        start(2'b01, 0);
        wait_out(lat);
        out_ready = 1'b1; stats_clr = 1'b1;
        tick;
        out_ready = 1'b0; stats_clr = 1'b0;
        n_vec++; if (eval_count !== 32'd0) begin n_err++; $display("FAIL stats_clr_wins: got %0d want 0", eval_count); end
    endtask
`endif

    initial begin
        test_reset;
        test_xor;
        test_const;
        test_backpressure;
        test_back_to_back;
        test_prog_busy;
        test_reset_eval;
`ifdef AIG_EVAL_STATS_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
